// File: rtl/dcache_pkg.sv
// Shared geometry, FSM states and line metadata for the direct-mapped write-back data cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

  // Cache geometry. The top-level parameters default to these values and must agree with them.
  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 64;

  localparam int IDX_W  = $clog2(LINES);
  localparam int WORD_W = $clog2(WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - WORD_W - 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } meta_t;

endpackage

// File: rtl/dcache_ctrl.sv
// Miss engine: walks the line beat by beat, first writing back a dirty victim, then refilling.
// Latency: one ack per beat; WORDS beats per phase, returns to IDLE on the last refill ack.
// Backpressure: mem_req/mem_we and the beat index hold until mem_ack; acks outside WB/REFILL are ignored.
module dcache_ctrl (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_miss,
  input  logic                         i_victim_dirty,
  input  logic                         i_mem_ack,
  output logic                         o_in_wb,
  output logic                         o_in_refill,
  output logic [dcache_pkg::WORD_W-1:0] o_beat,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic                         o_fill_we,
  output logic                         o_wb_done,
  output logic                         o_fill_done
);
  import dcache_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_beat;
  logic [WORD_W-1:0] w_beat_nxt;
  logic              w_last;

  assign w_last      = (r_beat == WORD_W'(WORDS - 1));
  assign o_in_wb     = (r_state == WB);
  assign o_in_refill = (r_state == REFILL);
  assign o_beat      = r_beat;

  // State and beat registers; reset abandons any miss in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next state, beat advance on each ack, and memory handshake strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_fill_we   = 1'b0;
    o_wb_done   = 1'b0;
    o_fill_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_miss) begin
          w_state_nxt = i_victim_dirty ? WB : REFILL;
          w_beat_nxt  = '0;
        end
      end
      WB: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ack) begin
          if (w_last) begin
            o_wb_done   = 1'b1;
            w_state_nxt = REFILL;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      REFILL: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_fill_we = 1'b1;
          if (w_last) begin
            o_fill_done = 1'b1;
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped write-back write-allocate data cache between the memory stage and data memory.
// Latency: hits complete in the issuing cycle; misses stall through WB/REFILL, then hit one cycle later.
// Backpressure: cpu_stall holds the pipeline; memory side is a req-held-until-ack word handshake.
module dcache_dm_wb #(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [63:0]       cpu_wdata,
  output logic [63:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);
  import dcache_pkg::*;

  meta_t             r_meta [LINES];
  logic [63:0]       r_data [LINES][WORDS];

  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  meta_t             w_line;
  logic              w_hit;
  logic              w_miss;
  logic              w_store;
  logic              w_in_wb;
  logic              w_in_refill;
  logic              w_in_idle;
  logic [WORD_W-1:0] w_beat;
  logic              w_fill_we;
  logic              w_wb_done;
  logic              w_fill_done;
  logic              w_unused_lsb;

  // Byte offset within the 8-byte word carries no information for 64-bit-only transfers.
  assign w_unused_lsb = ^cpu_addr[2:0];

  assign w_word = cpu_addr[3 +: WORD_W];
  assign w_idx  = cpu_addr[3 + WORD_W +: IDX_W];
  assign w_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_line = r_meta[w_idx];

  assign w_hit     = cpu_req & w_line.valid & (w_line.tag == w_tag);
  assign w_miss    = cpu_req & ~w_hit;
  assign w_in_idle = ~(w_in_wb | w_in_refill);
  assign w_store   = w_in_idle & w_hit & cpu_we;

  assign cpu_stall = w_in_idle ? w_miss : 1'b1;
  assign cpu_rdata = r_data[w_idx][w_word];

  // Writeback targets the victim's address, refill the requester's; both zero when idle.
  assign mem_addr  = w_in_wb     ? ADDR_W'({w_line.tag, w_idx, w_beat, 3'b000}) :
                     w_in_refill ? ADDR_W'({w_tag,      w_idx, w_beat, 3'b000}) : '0;
  assign mem_wdata = w_in_wb ? r_data[w_idx][w_beat] : 64'd0;

  dcache_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .i_miss         (w_miss),
    .i_victim_dirty (w_line.valid & w_line.dirty),
    .i_mem_ack      (mem_ack),
    .o_in_wb        (w_in_wb),
    .o_in_refill    (w_in_refill),
    .o_beat         (w_beat),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_fill_we      (w_fill_we),
    .o_wb_done      (w_wb_done),
    .o_fill_done    (w_fill_done)
  );

  // Line metadata: reset invalidates everything (a dirty victim mid-writeback is lost on purpose).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) r_meta[i] <= '0;
    end else if (w_fill_done) begin
      r_meta[w_idx] <= '{valid: 1'b1, dirty: 1'b0, tag: w_tag};
    end else if (w_wb_done) begin
      r_meta[w_idx].dirty <= 1'b0;
    end else if (w_store) begin
      r_meta[w_idx].dirty <= 1'b1;
    end
  end

  // Data array: refill beats from memory, store hits from the pipeline; nothing lands during reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fill_we) r_data[w_idx][w_beat] <= mem_rdata;
      else if (w_store) r_data[w_idx][w_word] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Scoreboard bench: a flat-memory reference plus a tag directory predicts load data and bus traffic.
// Latency: checks hits complete in the issue cycle and misses one cycle after the last ack.
// Backpressure: the memory responder inserts fixed or random ack delays and spurious idle acks.
module tb_dcache_dm_wb;

  localparam int NL = 16;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  dcache_dm_wb #(.LINES(NL), .WORDS(NW), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int ack_count = 0;
  int ack_delay = 0;
  bit rand_mode = 1'b0;
  bit issue_stall;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit we; logic [63:0] rdata; bit miss; int issue_cyc; } cpu_exp_t;
  typedef struct { bit we; logic [63:0] addr; logic [63:0] wdata; } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // ref_mem: architectural view; cmem: what backing memory should hold; bmem: responder storage.
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] cmem[logic [63:0]];
  logic [63:0] bmem[logic [63:0]];
  bit          mvalid[NL];
  bit          mdirty[NL];
  logic [63:0] mtag[NL];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] init_word(input logic [63:0] a);
    if (a >= 64'h100 && a < 64'h120) return 64'hA0 + (a - 64'h100) / 8;
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [63:0] cmem_rd(input logic [63:0] a);
    return cmem.exists(a) ? cmem[a] : init_word(a);
  endfunction
  function automatic logic [63:0] bmem_rd(input logic [63:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] line_addr(input logic [63:0] tag, input int idx, input int w);
    return (tag << 9) | (64'(idx) << 5) | (64'(w) << 3);
  endfunction

  // Predict the outcome of one access and queue the expected CPU result and bus beats.
  function automatic void model_issue(input bit we, input logic [63:0] a, input logic [63:0] d);
    logic [63:0] wa;
    logic [63:0] tag;
    logic [63:0] v;
    int          idx;
    cpu_exp_t    e;
    wa  = {a[63:3], 3'b000};
    idx = int'(wa[8:5]);
    tag = wa >> 9;
    e.miss = !(mvalid[idx] && mtag[idx] == tag);
    if (e.miss) begin
      if (mvalid[idx] && mdirty[idx]) begin
        for (int w = 0; w < NW; w++) begin
          v = ref_rd(line_addr(mtag[idx], idx, w));
          cmem[line_addr(mtag[idx], idx, w)] = v;
          mem_q.push_back('{1'b1, line_addr(mtag[idx], idx, w), v});
        end
      end
      for (int w = 0; w < NW; w++) mem_q.push_back('{1'b0, line_addr(tag, idx, w), 64'd0});
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
      mtag[idx]   = tag;
    end
    if (we) begin
      ref_mem[wa] = d;
      mdirty[idx] = 1'b1;
    end
    e.we        = we;
    e.rdata     = ref_rd(wa);
    e.issue_cyc = cyc;
    cpu_q.push_back(e);
  endfunction

  // Reset discards cached state: unwritten dirty data reverts to what memory holds.
  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      if (mvalid[i] && mdirty[i])
        for (int w = 0; w < NW; w++) ref_mem[line_addr(mtag[i], i, w)] = cmem_rd(line_addr(mtag[i], i, w));
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    cpu_q.delete();
    mem_q.delete();
  endfunction

  task automatic access(input bit we, input logic [63:0] a, input logic [63:0] d);
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    model_issue(we, a, d);
    #3;
    issue_stall = cpu_stall;
    n = 0;
    while (cpu_stall && n < 500) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 500) chk("access_timeout", 64'(n), 64'd0);
  endtask

  // Memory responder: acks each beat after a delay, services reads/writes from bmem.
  initial begin
    int cnt, tgt;
    bit waiting;
    cnt = 0; tgt = 0; waiting = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !reset) begin
        if (!waiting) begin
          waiting = 1'b1;
          cnt = 0;
          tgt = rand_mode ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (cnt == tgt) begin
          mem_ack = 1'b1;
          waiting = 1'b0;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = bmem_rd(mem_addr);
        end else begin
          cnt++;
        end
      end else begin
        waiting = 1'b0;
        if (rand_mode && $urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // Memory-side monitor: beat order/contents against the scoreboard, and hold stability while waiting.
  initial begin
    mem_exp_t    e;
    bit          pend;
    bit          pwe;
    logic [63:0] paddr, pwd;
    pend = 1'b0; pwe = 1'b0; paddr = '0; pwd = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("mem_req_held", 64'(mem_req), 64'd1);
          chk("mem_addr_stable", mem_addr, paddr);
          chk("mem_we_stable", 64'(mem_we), 64'(pwe));
          if (pwe) chk("mem_wdata_stable", mem_wdata, pwd);
        end
        if (mem_req && mem_ack) begin
          ack_count++;
          last_ack_cyc = cyc;
          if (mem_q.size() == 0) begin
            chk("mem_unexpected_beat", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = mem_q.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", 64'(mem_we), 64'(e.we));
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          end
          pend = 1'b0;
        end else begin
          pend = mem_req; paddr = mem_addr; pwe = mem_we; pwd = mem_wdata;
        end
      end
    end
  end

  // CPU-side monitor: each completing access pops its expectation.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset && cpu_req && !cpu_stall) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_unexpected_completion", cpu_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = cpu_q.pop_front();
          if (!e.we) chk("load_data", cpu_rdata, e.rdata);
          if (e.miss) chk("miss_done_cycle", 64'(cyc), 64'(last_ack_cyc + 1));
          else chk("hit_done_cycle", 64'(cyc), 64'(e.issue_cyc));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [63:0] a;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    chk("reset_stall_idle", 64'(cpu_stall), 64'd0);
    reset = 1'b0;
    model_reset();

    // Cold load miss, then hit in the same line, then dirty conflict.
    access(1'b0, 64'h100, 64'd0);
    chk("t1_first_access_stalls", 64'(issue_stall), 64'd1);
    access(1'b0, 64'h108, 64'd0);
    chk("t2_hit_no_stall", 64'(issue_stall), 64'd0);
    access(1'b1, 64'h110, 64'hDEAD);
    chk("t3_store_hit_no_stall", 64'(issue_stall), 64'd0);
    access(1'b0, 64'h310, 64'd0);
    chk("t3_conflict_stalls", 64'(issue_stall), 64'd1);

    // Store miss with clean victim, then conflicting load forces its writeback.
    access(1'b1, 64'h500, 64'h1234_5678_9ABC_DEF0);
    access(1'b0, 64'h700, 64'd0);
    access(1'b0, 64'h500, 64'd0);

    // Slow memory: three idle cycles before every ack.
    ack_delay = 3;
    access(1'b0, 64'h1040, 64'd0);
    access(1'b1, 64'h1048, 64'hFEED);
    access(1'b0, 64'h1240, 64'd0);
    access(1'b1, 64'h1250, 64'hBEEF);
    access(1'b0, 64'h1048, 64'd0);

    // Reset in the middle of a refill, then the same address must miss again.
    ack_delay = 1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h920;
    model_issue(1'b0, 64'h920, 64'd0);
    base = ack_count;
    n = 0;
    while (ack_count < base + 2 && n < 100) begin
      @(negedge clk); #4;
      n++;
    end
    chk("t6_reached_beat2", 64'(ack_count - base), 64'd2);
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    model_reset();
    @(negedge clk); #3;
    chk("t6_mem_req_after_reset", 64'(mem_req), 64'd0);
    chk("t6_mem_addr_after_reset", mem_addr, 64'd0);
    reset = 1'b0;
    access(1'b0, 64'h920, 64'd0);
    chk("t6_reaccess_misses", 64'(issue_stall), 64'd1);
    access(1'b0, 64'h1250, 64'd0);

    // Random traffic over a small conflict-heavy address pool with random ack timing.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = (64'($urandom_range(0, 1)) << 60) | (64'($urandom_range(0, 2)) << 9) |
          (64'($urandom_range(0, 3)) << 5) | (64'($urandom_range(0, 3)) << 3) |
          64'($urandom_range(0, 7));
      access(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end

    @(negedge clk);
    cpu_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);
    chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
